// File: rtl/ob_rsp_egress.sv
// rtl/ob_rsp_egress.sv - order-book response egress FIFO
// Buffers controller responses, drains them over valid/ready, tracks overflow and trades.
package ob_pkg;
  typedef enum logic [1:0] {
    S_Okay   = 2'd0,
    S_Reject = 2'd1,
    S_Empty  = 2'd2,
    S_Full   = 2'd3
  } status_t;

  typedef struct packed {
    logic [7:0]  uid;
    status_t     status;
    logic [15:0] price;
    logic [7:0]  qty;
  } rsp_t;
endpackage

module ob_rsp_egress #(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rsp_in_vld,
  input  ob_pkg::rsp_t               rsp_in,
  output logic                       rsp_in_full_r,
  output logic                       afull_r,
  output logic                       rsp_out_vld,
  output ob_pkg::rsp_t               rsp_out,
  input  logic                       rsp_out_rdy,
  output logic [$clog2(DEPTH):0]     occupancy_r,
  output logic                       overflow_r,
  output logic [CNT_W-1:0]           trade_cnt_r,
  input  logic                       stat_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  ob_pkg::rsp_t      mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  trade_cnt_q, trade_cnt_d;
  logic              push, pop, is_trade;

  assign rsp_out_vld   = (occ_q != '0);
  // Gate the head with valid so an empty FIFO (including after reset) shows zero.
  assign rsp_out       = rsp_out_vld ? mem_q[rd_ptr_q] : '0;
  assign rsp_in_full_r = full_q;
  assign afull_r       = afull_q;
  assign occupancy_r   = occ_q;
  assign overflow_r    = overflow_q;
  assign trade_cnt_r   = trade_cnt_q;

  always_comb begin
    pop         = rsp_out_vld & rsp_out_rdy;
    push        = rsp_in_vld & (~full_q | pop);
    is_trade    = pop & (rsp_out.uid == '1) & (rsp_out.status == ob_pkg::S_Okay);
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q;
    trade_cnt_d = trade_cnt_q;

    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    // Flags come from the next occupancy so they track occupancy_r exactly.
    full_d  = (occ_d == OW'(DEPTH));
    afull_d = (occ_d >= OW'(AFULL_LVL));

    if (rsp_in_vld & full_q & ~pop) overflow_d = 1'b1;
    if (is_trade && trade_cnt_q != '1) trade_cnt_d = trade_cnt_q + CNT_W'(1);
    if (stat_clr) begin
      overflow_d  = 1'b0;
      trade_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      trade_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      trade_cnt_q <= trade_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rsp_in;
  end
endmodule

// File: tb/tb_ob_rsp_egress.sv
// tb/tb_ob_rsp_egress.sv - directed bench for ob_rsp_egress
// Runs with CNT_W=2 so trade-counter saturation is reachable quickly.
module tb_ob_rsp_egress;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rsp_in_vld = 1'b0;
  ob_pkg::rsp_t       rsp_in = '0;
  logic               rsp_in_full_r;
  logic               afull_r;
  logic               rsp_out_vld;
  ob_pkg::rsp_t       rsp_out;
  logic               rsp_out_rdy = 1'b0;
  logic [2:0]         occupancy_r;
  logic               overflow_r;
  logic [1:0]         trade_cnt_r;
  logic               stat_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  ob_rsp_egress #(.DEPTH(4), .AFULL_LVL(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .rsp_in_vld(rsp_in_vld), .rsp_in(rsp_in),
    .rsp_in_full_r(rsp_in_full_r), .afull_r(afull_r),
    .rsp_out_vld(rsp_out_vld), .rsp_out(rsp_out), .rsp_out_rdy(rsp_out_rdy),
    .occupancy_r(occupancy_r), .overflow_r(overflow_r),
    .trade_cnt_r(trade_cnt_r), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  function automatic ob_pkg::rsp_t mk(input logic [7:0] uid, input ob_pkg::status_t st,
                                      input logic [15:0] px);
    ob_pkg::rsp_t r;
    r.uid = uid; r.status = st; r.price = px; r.qty = px[7:0] ^ 8'h5A;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle();
    checks++; if (occupancy_r !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy_r); end
    checks++; if ({rsp_out_vld, rsp_in_full_r, afull_r, overflow_r} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rsp_out_vld, rsp_in_full_r, afull_r, overflow_r}); end
    checks++; if (rsp_out !== '0 || trade_cnt_r !== 2'd0) begin errors++; $display("FAIL reset_data: got %h/%0d expected 0/0", rsp_out, trade_cnt_r); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_latency();
    ob_pkg::rsp_t a;
    a = mk(8'h11, ob_pkg::S_Okay, 16'h1234);
    rsp_out_rdy = 1'b1; rsp_in_vld = 1'b1; rsp_in = a;
    cycle();
    rsp_in_vld = 1'b0;
    checks++; if (rsp_out_vld !== 1'b1 || rsp_out !== a) begin errors++; $display("FAIL lat_head: got %b/%h expected 1/%h", rsp_out_vld, rsp_out, a); end
    checks++; if (occupancy_r !== 3'd1) begin errors++; $display("FAIL lat_occ1: got %0d expected 1", occupancy_r); end
    cycle();
    checks++; if (occupancy_r !== 3'd0 || rsp_out_vld !== 1'b0) begin errors++; $display("FAIL lat_drain: got %0d/%b expected 0/0", occupancy_r, rsp_out_vld); end
  endtask

  task automatic test_fill_overflow();
    ob_pkg::rsp_t e [5];
    for (int i = 0; i < 5; i++) e[i] = mk(8'h20 + 8'(i), ob_pkg::S_Reject, 16'hA000 + 16'(i));
    rsp_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_in_vld = 1'b1; rsp_in = e[i];
      cycle();
      if (i == 2) begin
        checks++; if (afull_r !== 1'b1 || rsp_in_full_r !== 1'b0) begin errors++; $display("FAIL fill_afull3: got %b%b expected 10", afull_r, rsp_in_full_r); end
      end
    end
    checks++; if (rsp_in_full_r !== 1'b1 || afull_r !== 1'b1 || occupancy_r !== 3'd4) begin errors++; $display("FAIL fill_full: got %b%b occ %0d expected 11 occ 4", rsp_in_full_r, afull_r, occupancy_r); end
    rsp_in = e[4];
    cycle();
    rsp_in_vld = 1'b0;
    checks++; if (overflow_r !== 1'b1 || occupancy_r !== 3'd4) begin errors++; $display("FAIL ovf_set: got %b occ %0d expected 1 occ 4", overflow_r, occupancy_r); end
    cycle();
    checks++; if (rsp_out !== e[0]) begin errors++; $display("FAIL ovf_stable_head: got %h expected %h", rsp_out, e[0]); end
    rsp_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_out !== e[i] || rsp_out_vld !== 1'b1) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", i, rsp_out, e[i]); end
      cycle();
    end
    checks++; if (occupancy_r !== 3'd0 || overflow_r !== 1'b1) begin errors++; $display("FAIL ovf_empty: got occ %0d ovf %b expected 0/1", occupancy_r, overflow_r); end
    stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
    checks++; if (overflow_r !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow_r); end
  endtask

  task automatic test_full_push_pop();
    ob_pkg::rsp_t f [5];
    for (int i = 0; i < 5; i++) f[i] = mk(8'h40 + 8'(i), ob_pkg::S_Empty, 16'hB000 + 16'(i));
    rsp_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin rsp_in_vld = 1'b1; rsp_in = f[i]; cycle(); end
    rsp_out_rdy = 1'b1; rsp_in = f[4];
    cycle();
    rsp_in_vld = 1'b0;
    checks++; if (occupancy_r !== 3'd4 || overflow_r !== 1'b0 || rsp_in_full_r !== 1'b1) begin errors++; $display("FAIL pp_full: got occ %0d ovf %b full %b expected 4/0/1", occupancy_r, overflow_r, rsp_in_full_r); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (rsp_out !== f[i]) begin errors++; $display("FAIL pp_order%0d: got %h expected %h", i, rsp_out, f[i]); end
      cycle();
    end
    checks++; if (occupancy_r !== 3'd0 || rsp_in_full_r !== 1'b0 || afull_r !== 1'b0) begin errors++; $display("FAIL pp_empty: got occ %0d full %b afull %b expected 0/0/0", occupancy_r, rsp_in_full_r, afull_r); end
  endtask

  task automatic test_trades();
    ob_pkg::rsp_t t [5];
    int n;
    t[0] = mk(8'hFF, ob_pkg::S_Okay, 16'h0100);
    t[1] = mk(8'hFF, ob_pkg::S_Okay, 16'h0101);
    t[2] = mk(8'hFF, ob_pkg::S_Reject, 16'h0102);
    t[3] = mk(8'hFF, ob_pkg::S_Okay, 16'h0103);
    t[4] = mk(8'h00, ob_pkg::S_Okay, 16'h0104);
    rsp_out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin rsp_in_vld = 1'b1; rsp_in = t[i]; cycle(); end
    rsp_in_vld = 1'b0;
    n = 0;
    while (occupancy_r != 3'd0 && n < 10) begin cycle(); n++; end
    checks++; if (occupancy_r !== 3'd0) begin errors++; $display("FAIL trade_drain_timeout: got occ %0d expected 0", occupancy_r); end
    checks++; if (trade_cnt_r !== 2'd3) begin errors++; $display("FAIL trade_cnt3: got %0d expected 3", trade_cnt_r); end
    rsp_in_vld = 1'b1; rsp_in = mk(8'hFF, ob_pkg::S_Okay, 16'h0105);
    cycle(); rsp_in_vld = 1'b0; cycle();
    checks++; if (trade_cnt_r !== 2'd3) begin errors++; $display("FAIL trade_sat: got %0d expected 3", trade_cnt_r); end
    stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
    checks++; if (trade_cnt_r !== 2'd0) begin errors++; $display("FAIL trade_clr: got %0d expected 0", trade_cnt_r); end
  endtask

  task automatic test_clr_vs_overflow();
    rsp_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin rsp_in_vld = 1'b1; rsp_in = mk(8'h60 + 8'(i), ob_pkg::S_Okay, 16'(i)); cycle(); end
    stat_clr = 1'b1; rsp_in = mk(8'h70, ob_pkg::S_Okay, 16'h7070);
    cycle();
    stat_clr = 1'b0; rsp_in_vld = 1'b0;
    checks++; if (overflow_r !== 1'b0 || occupancy_r !== 3'd4) begin errors++; $display("FAIL clr_prio: got ovf %b occ %0d expected 0/4", overflow_r, occupancy_r); end
  endtask

  task automatic test_reset_mid();
    ob_pkg::rsp_t g;
    g = mk(8'h99, ob_pkg::S_Reject, 16'hC0DE);
    rsp_out_rdy = 1'b1; cycle();
    checks++; if (occupancy_r !== 3'd3) begin errors++; $display("FAIL rmid_pre: got occ %0d expected 3", occupancy_r); end
    rsp_out_rdy = 1'b0;
    #2 rsp_out_rdy = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++; if ({rsp_out_vld, rsp_in_full_r, afull_r, overflow_r} !== 4'b0 || occupancy_r !== 3'd0 || rsp_out !== '0) begin errors++; $display("FAIL rmid_async: got vld %b occ %0d out %h expected 0/0/0", rsp_out_vld, occupancy_r, rsp_out); end
    @(negedge clk); rst = 1'b0;
    rsp_in_vld = 1'b1; rsp_in = g;
    cycle();
    rsp_in_vld = 1'b0;
    checks++; if (rsp_out_vld !== 1'b1 || rsp_out !== g || occupancy_r !== 3'd1) begin errors++; $display("FAIL rmid_after: got %b/%h occ %0d expected 1/%h occ 1", rsp_out_vld, rsp_out, occupancy_r, g); end
    cycle();
    checks++; if (occupancy_r !== 3'd0) begin errors++; $display("FAIL rmid_drain: got occ %0d expected 0", occupancy_r); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_overflow();
    test_full_push_pop();
    test_trades();
    test_clr_vs_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
